// File: rtl/cksum_engine.sv
// cksum_engine: Internet-style 16-bit one's-complement checksum over a byte
// field held in a 32-bit, big-endian-lane SRAM. Optionally writes the result
// back as a halfword, or checks it in verify mode.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  request (sampled in IDLE only)
//   mode_i                   0 = compute, 1 = verify
//   wb_en_i                  write result back to wb_addr_i (compute mode)
//   field_start_i            first byte address of the field
//   field_len_i              field length in bytes
//   seed_i                   initial partial sum
//   wb_addr_i                halfword write-back address (must be even)
//   sram_*                   SRAM port: word-aligned address, byte selects
//   busy_o, done_o           status
//   cksum_val_o, cksum_ok_o  result, verify pass
//   err_o                    odd write-back address requested
module cksum_engine #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] field_start_i,
  input  logic [LEN_W-1:0]  field_len_i,
  input  logic [15:0]       seed_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       cksum_val_o,
  output logic              cksum_ok_o,
  output logic              err_o
);

  localparam int ACC_W = 16 + LEN_W;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, FOLD, SEED, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic              mode_q, wb_en_q, odd_q;
  logic [ADDR_W:0]   fstart_q, fend_q;   // one extra bit so the end never wraps
  logic [15:0]       seed_q, sum16;
  logic [ADDR_W-1:0] wb_addr_q, rd_addr, last_addr;
  logic [2:0]        drain_cnt;
  logic [ACC_W-1:0]  acc;

  // Read-return tracking: bit/entry RD_LAT-1 lines up with sram_data_i.
  logic [RD_LAT-1:0]      vld_pipe;
  logic [RD_LAT-1:0][3:0] msk_pipe;

  logic [3:0]        rd_msk;
  logic [31:0]       rd_data_m;
  logic [ACC_W-1:0]  acc_add, fold_val;
  logic [16:0]       seed_sum;
  logic [15:0]       s_fin;
  logic [ADDR_W-1:0] end_m1;
  logic              do_wb, fold_done;

  assign end_m1    = field_start_i + ADDR_W'(field_len_i) - ADDR_W'(1);
  assign do_wb     = wb_en_q & ~mode_q & ~wb_addr_q[0];
  assign fold_done = (acc[ACC_W-1:16] == '0);
  assign fold_val  = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);
  assign seed_sum  = {1'b0, sum16} + {1'b0, seed_q};
  assign s_fin     = seed_sum[15:0] + {15'b0, seed_sum[16]};
  assign acc_add   = ACC_W'(rd_data_m[31:16]) + ACC_W'(rd_data_m[15:0]);

  // Byte-lane masks for the word being issued; mask bit 3 is lane 0 (data[31:24]).
  // Sums are taken on absolute halfwords; an odd start is fixed by a byte swap later.
  always_comb begin
    rd_msk    = '0;
    rd_data_m = '0;
    for (int b = 0; b < 4; b++) begin
      rd_msk[3-b] = (({1'b0, rd_addr} | (ADDR_W+1)'(b)) >= fstart_q) &&
                    (({1'b0, rd_addr} | (ADDR_W+1)'(b)) <  fend_q);
      rd_data_m[31-8*b -: 8] = msk_pipe[RD_LAT-1][3-b] ? sram_data_i[31-8*b -: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sram_ce_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = '0;
    sram_sel_o  = 4'b0000;
    sram_data_o = '0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = (field_len_i == '0) ? FOLD : READ;
      end
      READ: begin
        sram_ce_o   = 1'b1;
        sram_addr_o = rd_addr;
        sram_sel_o  = 4'b1111;
        if (rd_addr == last_addr) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == 3'(RD_LAT - 1)) state_nxt = FOLD;
      FOLD:  if (fold_done) state_nxt = SEED;
      SEED:  state_nxt = do_wb ? WRITE : DONE;
      WRITE: begin
        sram_ce_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = {wb_addr_q[ADDR_W-1:2], 2'b00};
        sram_sel_o  = wb_addr_q[1] ? 4'b0011 : 4'b1100;
        sram_data_o = {cksum_val_o, cksum_val_o};
        state_nxt   = DONE;
      end
      DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        if (!start_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      odd_q       <= 1'b0;
      fstart_q    <= '0;
      fend_q      <= '0;
      seed_q      <= '0;
      wb_addr_q   <= '0;
      rd_addr     <= '0;
      last_addr   <= '0;
      drain_cnt   <= '0;
      acc         <= '0;
      sum16       <= '0;
      vld_pipe    <= '0;
      msk_pipe    <= '0;
      cksum_val_o <= '0;
      cksum_ok_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      vld_pipe[0] <= (state == READ);
      msk_pipe[0] <= rd_msk;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        msk_pipe[i] <= msk_pipe[i-1];
      end
      if (vld_pipe[RD_LAT-1]) acc <= acc + acc_add;

      case (state)
        IDLE: if (start_i) begin
          mode_q    <= mode_i;
          wb_en_q   <= wb_en_i;
          odd_q     <= field_start_i[0];
          fstart_q  <= {1'b0, field_start_i};
          fend_q    <= {1'b0, field_start_i} + (ADDR_W+1)'(field_len_i);
          seed_q    <= seed_i;
          wb_addr_q <= wb_addr_i;
          rd_addr   <= {field_start_i[ADDR_W-1:2], 2'b00};
          last_addr <= {end_m1[ADDR_W-1:2], 2'b00};
          acc       <= '0;
        end
        READ: begin
          if (rd_addr != last_addr) rd_addr <= rd_addr + ADDR_W'(4);
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + 3'd1;
        FOLD: begin
          if (!fold_done)  acc   <= fold_val;
          else if (odd_q)  sum16 <= {acc[7:0], acc[15:8]};
          else             sum16 <= acc[15:0];
        end
        SEED: begin
          cksum_val_o <= ~s_fin;
          cksum_ok_o  <= mode_q && (s_fin == 16'hFFFF);
          err_o       <= wb_en_q & wb_addr_q[0];
        end
        DONE: if (!start_i) err_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
